mem_stage_lsu: RTL and testbench

- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Turns load/store instructions into word-aligned data-memory bus transactions using a req/ack handshake.
- Stalls the pipeline while a transaction is outstanding.
- Aligns, masks and sign/zero-extends load data, then passes ALU result, rd and control through to MEM/WB.

---
 rtl/mem_stage_lsu.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Purpose: MEM stage; turns loads/stores into word-aligned req/ack bus transactions, extends load data, passes other fields to MEM/WB.
// Latency: non-memory ops 0 cycles (combinational); memory ops at least 3 cycles (IDLE issue, BUSY until ack, DONE).
// Backpressure: o_stall freezes PC..EX/MEM from issue until ack; waits on i_dmem_ack indefinitely unless LSU_TIMEOUT_EN bounds it.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_mem_load,
    input  logic        i_mem_store,
    input  logic        i_mem_wreg,
    input  logic [2:0]  i_mem_funct3,
    input  logic [4:0]  i_mem_rd,
    input  logic [31:0] i_mem_alu,
    input  logic [31:0] i_mem_sdata,
    output logic        o_mem_mem2reg,
    output logic        o_mem_wreg,
    output logic [4:0]  o_mem_rd,
    output logic [31:0] o_mem_data,
    output logic [31:0] o_rd_dmem,
    output logic        o_stall,
    output logic        o_mem_fault,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rd_dmem;

    logic        w_access;
    logic [1:0]  w_off;
    logic        w_legal;
    logic        w_bad;
    logic        w_start;
    logic        w_tmo_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_ext;

    assign w_access = i_mem_load | i_mem_store;
    assign w_off    = i_mem_alu[1:0];

    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = i_mem_sdata;
        case (i_mem_funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{i_mem_sdata[7:0]}};
            end
            3'b001: begin
                w_legal = ~w_off[0];
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{i_mem_sdata[15:0]}};
            end
            3'b010: begin
                w_legal = (w_off == 2'b00);
                w_be    = 4'hF;
            end
            3'b100: begin
                w_legal = ~i_mem_store;
                w_be    = 4'b0001 << w_off;
            end
            3'b101: begin
                w_legal = ~i_mem_store & ~w_off[0];
                w_be    = 4'b0011 << w_off;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_bad   = w_access & ~w_legal;
    assign w_start = (r_state == S_IDLE) & w_access & w_legal;

    assign w_lane = i_dmem_rdata >> {w_off, 3'b000};
    always_comb begin
        w_ext = w_lane;
        case (i_mem_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'b0, w_lane[7:0]};
            3'b101:  w_ext = {16'b0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_cnt;
    logic          r_tmo;
    assign w_tmo_fault = (r_state == S_DONE) & r_tmo;
`else
    assign w_tmo_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'b0;
            r_wdata   <= 32'b0;
            r_be      <= 4'b0;
            r_rd_dmem <= 32'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt     <= '0;
            r_tmo     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= i_mem_store;
                        r_addr  <= {i_mem_alu[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_dmem_ack) begin
                        r_req   <= 1'b0;
                        if (i_mem_load) r_rd_dmem <= w_ext;
                        r_state <= S_DONE;
`ifdef LSU_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_req     <= 1'b0;
                        r_rd_dmem <= 32'b0;
                        r_tmo     <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
`endif
                    end
                end
                S_DONE: begin
`ifdef LSU_TIMEOUT_EN
                    r_tmo   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall       = w_start | (r_state == S_BUSY);
    assign o_mem_fault   = w_bad | w_tmo_fault;
    assign o_mem_wreg    = i_mem_wreg & ~o_mem_fault;
    assign o_mem_mem2reg = i_mem_load;
    assign o_mem_rd      = i_mem_rd;
    assign o_mem_data    = i_mem_alu;
    assign o_rd_dmem     = r_rd_dmem;
    assign o_dmem_req    = r_req;
    assign o_dmem_we     = r_we;
    assign o_dmem_addr   = r_addr;
    assign o_dmem_wdata  = r_wdata;
    assign o_dmem_be     = r_be;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Purpose: directed bench for mem_stage_lsu; expected outputs computed from size/offset arithmetic.
// Latency: checks outputs each negedge against a cycle-accurate model of the IDLE/BUSY/DONE sequence.
// Backpressure: drives ack after a chosen delay, or never (timeout build) to exercise o_stall hold.
module tb_mem_stage_lsu;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ld, st, wr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, sdata;
    logic        ack;
    logic [31:0] rdata;

    logic        o_mem_mem2reg, o_mem_wreg, o_stall, o_mem_fault;
    logic        o_dmem_req, o_dmem_we;
    logic [4:0]  o_mem_rd;
    logic [31:0] o_mem_data, o_rd_dmem, o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_resetn(rst_n),
        .i_mem_load(ld), .i_mem_store(st), .i_mem_wreg(wr), .i_mem_funct3(f3),
        .i_mem_rd(rd), .i_mem_alu(alu), .i_mem_sdata(sdata),
        .o_mem_mem2reg(o_mem_mem2reg), .o_mem_wreg(o_mem_wreg), .o_mem_rd(o_mem_rd),
        .o_mem_data(o_mem_data), .o_rd_dmem(o_rd_dmem), .o_stall(o_stall),
        .o_mem_fault(o_mem_fault), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(ack), .i_dmem_rdata(rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int f_size(input logic [2:0] fn);
        case (fn[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit f_legal(input bit l, input bit s, input logic [2:0] fn, input int a);
        if (!(l || s)) return 1'b1;
        if (f_size(fn) == 0 || fn[2:1] == 2'b11) return 1'b0;
        if (fn[2] && s) return 1'b0;
        return (a % f_size(fn)) == 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] fn, input int a);
        int m;
        m = ((1 << f_size(fn)) - 1) << a;
        return m[3:0];
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] fn, input logic [31:0] d);
        if (f_size(fn) == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (f_size(fn) == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] f_ext(input logic [2:0] fn, input logic [31:0] w, input int a);
        longint v, mask;
        int bits;
        bits = 8 * f_size(fn);
        mask = (64'd1 << bits) - 1;
        v = (longint'(w) >> (8 * a)) & mask;
        if (!fn[2] && bits < 32 && v[bits-1]) v = v | (~mask);
        return v[31:0];
    endfunction

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_fault, exp_wreg, exp_m2r, exp_req, exp_we;
    logic [4:0]  exp_rd5;
    logic [31:0] exp_data, exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",   o_stall,       exp_stall);
            chk("fault",   o_mem_fault,   exp_fault);
            chk("wreg",    o_mem_wreg,    exp_wreg);
            chk("mem2reg", o_mem_mem2reg, exp_m2r);
            chk("rd",      o_mem_rd,      exp_rd5);
            chk("data",    o_mem_data,    exp_data);
            chk("req",     o_dmem_req,    exp_req);
            chk("rd_dmem", o_rd_dmem,     exp_rd);
            if (exp_req) begin
                chk("addr", o_dmem_addr, exp_addr);
                chk("be",   o_dmem_be,   exp_be);
                chk("we",   o_dmem_we,   exp_we);
                if (exp_we) chk("wdata", o_dmem_wdata, exp_wdata);
            end
        end
    end

    int stall_cnt = 0;
    always @(negedge clk) if (o_stall === 1'b1) stall_cnt++;

    task automatic mem_op(input bit l, input bit s, input logic [2:0] fn, input logic [4:0] r,
                          input logic [31:0] a32, input logic [31:0] sd, input bit w,
                          input int ack_dly, input logic [31:0] rdw);
        int  a;
        int  nb;
        bit  legal;
        a = int'(a32[1:0]);
        legal = f_legal(l, s, fn, a);
        ld = l; st = s; f3 = fn; rd = r; alu = a32; sdata = sd; wr = w; ack = 1'b0;
        exp_data = a32; exp_rd5 = r; exp_m2r = l; exp_req = 1'b0;
        if (!(l || s) || !legal) begin
            exp_stall = 1'b0;
            exp_fault = !legal;
            exp_wreg  = w && legal;
            @(posedge clk); #1;
            return;
        end
        exp_fault = 1'b0; exp_wreg = w; exp_stall = 1'b1;
        exp_addr = {a32[31:2], 2'b00}; exp_be = f_be(fn, a); exp_we = s; exp_wdata = f_wdata(fn, sd);
        @(posedge clk); #1;
        exp_req = 1'b1;
        nb = (ack_dly > 0) ? ack_dly : TMO;
        for (int k = 1; k <= nb; k++) begin
            if (k == ack_dly) begin ack = 1'b1; rdata = rdw; end
            @(posedge clk); #1;
            ack = 1'b0; rdata = 32'hDEAD_BEEF;
        end
        exp_stall = 1'b0; exp_req = 1'b0;
        if (ack_dly == 0) begin
            exp_fault = 1'b1; exp_wreg = 1'b0; exp_rd = 32'h0;
        end else if (l) begin
            exp_rd = f_ext(fn, rdw, a);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; ld = 0; st = 0; wr = 0; f3 = 0; rd = 0; alu = 0; sdata = 0;
        ack = 0; rdata = 32'hDEAD_BEEF;
        exp_rd = 32'h0;
        #1;
        chk("rst_req",   o_dmem_req,   32'h0);
        chk("rst_we",    o_dmem_we,    32'h0);
        chk("rst_addr",  o_dmem_addr,  32'h0);
        chk("rst_wdata", o_dmem_wdata, 32'h0);
        chk("rst_be",    o_dmem_be,    32'h0);
        chk("rst_rdmem", o_rd_dmem,    32'h0);
        chk("rst_stall", o_stall,      32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        chk("model_lb",  f_ext(3'b000, 32'h80FF_0000, 3), 32'hFFFF_FF80);
        chk("model_lhu", f_ext(3'b101, 32'hBEEF_1234, 2), 32'h0000_BEEF);
        chk("model_sb",  f_wdata(3'b000, 32'h0000_00AB), 32'hABAB_ABAB);
        chk("model_beh", f_be(3'b001, 2), 32'hC);

        chk_en = 1'b1;
        mem_op(0, 0, 3'b000, 5'd5, 32'h1234, 32'h0, 1, 0, 0);
        chk("nop_data",  o_mem_data, 32'h1234);
        chk("nop_stall", o_stall,    32'h0);
        chk("nop_wreg",  o_mem_wreg, 32'h1);

        ack = 1'b1; rdata = 32'h5555_5555;
        @(posedge clk); #1;
        ack = 1'b0;

        stall_cnt = 0;
        mem_op(1, 0, 3'b000, 5'd7, 32'h103, 32'h0, 1, 2, 32'h80FF_0000);
        chk("lb_stall_cycles", stall_cnt, 32'd3);
        chk("lb_rdmem", o_rd_dmem,   32'hFFFF_FF80);
        chk("lb_be",    o_dmem_be,   32'h8);
        chk("lb_addr",  o_dmem_addr, 32'h100);

        mem_op(1, 0, 3'b101, 5'd8, 32'h202, 32'h0, 1, 1, 32'hBEEF_1234);
        chk("lhu_rdmem", o_rd_dmem, 32'h0000_BEEF);
        chk("lhu_be",    o_dmem_be, 32'hC);

        mem_op(0, 1, 3'b000, 5'd0, 32'h301, 32'h1234_56AB, 0, 3, 32'h0);
        chk("sb_we",    o_dmem_we,    32'h1);
        chk("sb_be",    o_dmem_be,    32'h2);
        chk("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
        chk("sb_addr",  o_dmem_addr,  32'h300);
        chk("sb_keep",  o_rd_dmem,    32'h0000_BEEF);

        mem_op(1, 0, 3'b010, 5'd9, 32'h402, 32'h0, 1, 1, 32'h0);
        chk("lw_mis_fault", o_mem_fault, 32'h1);
        chk("lw_mis_wreg",  o_mem_wreg,  32'h0);
        chk("lw_mis_stall", o_stall,     32'h0);

        mem_op(1, 0, 3'b001, 5'd10, 32'h0A2, 32'h0, 1, 1, 32'h8001_7FFF);
        chk("lh_rdmem", o_rd_dmem, 32'hFFFF_8001);
        mem_op(0, 1, 3'b001, 5'd0, 32'h0A2, 32'hCAFE_1234, 0, 2, 32'h0);
        chk("sh_wdata", o_dmem_wdata, 32'h1234_1234);
        mem_op(0, 1, 3'b010, 5'd0, 32'h0B0, 32'h0102_0304, 0, 1, 32'h0);
        mem_op(1, 0, 3'b100, 5'd11, 32'h0C1, 32'h0, 1, 4, 32'h0000_9A00);
        chk("lbu_rdmem", o_rd_dmem, 32'h0000_009A);
        mem_op(1, 0, 3'b010, 5'd12, 32'h0D0, 32'h0, 1, 1, 32'h7654_3210);
        mem_op(0, 1, 3'b001, 5'd0, 32'h011, 32'h0, 1, 1, 32'h0);
        mem_op(1, 0, 3'b011, 5'd13, 32'h020, 32'h0, 1, 1, 32'h0);
        mem_op(0, 1, 3'b100, 5'd0, 32'h020, 32'h0, 1, 1, 32'h0);
        mem_op(1, 0, 3'b101, 5'd14, 32'h023, 32'h0, 1, 1, 32'h0);
        mem_op(0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 0);

        chk_en = 1'b0;
        ld = 1; st = 0; f3 = 3'b000; rd = 5'd3; alu = 32'h500; wr = 1;
        @(posedge clk); #1;
        chk("rst_busy_req_pre", o_dmem_req, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy_req",   o_dmem_req, 32'h0);
        chk("rst_busy_rdmem", o_rd_dmem,  32'h0);
        ld = 0;
        #1;
        chk("rst_busy_idle", o_stall, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; ack = 1'b1; rdata = 32'h1111_1111;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("late_ack_req",   o_dmem_req, 32'h0);
        chk("late_ack_rdmem", o_rd_dmem,  32'h0);
        chk("late_ack_stall", o_stall,    32'h0);
        exp_rd = 32'h0;
        chk_en = 1'b1;

`ifdef LSU_TIMEOUT_EN
        stall_cnt = 0;
        mem_op(1, 0, 3'b010, 5'd15, 32'h600, 32'h0, 1, 0, 32'h0);
        chk("tmo_stall_cycles", stall_cnt, 32'd5);
        chk("tmo_rdmem",        o_rd_dmem, 32'h0);
`endif
        mem_op(0, 0, 3'b000, 5'd1, 32'h42, 32'h0, 1, 0, 0);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
